// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: data width, default
// halt word, FSM state encoding and small state-classification helpers.
package instr_sequencer_pkg;

  localparam int unsigned DATA_W = 16;

  localparam logic [DATA_W-1:0] DEF_HALT_WORD = 16'hFFFF;

  // FSM state encoding (3 bits, kept as plain constants for legacy users)
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  // A sequence is in progress only while fetching, issuing or waiting.
  function automatic logic state_is_busy(input logic [2:0] s);
    return (s == S_FETCH) || (s == S_ISSUE) || (s == S_WAIT);
  endfunction

  // States from which a new run may be launched (and the buffer reloaded).
  function automatic logic state_is_quiet(input logic [2:0] s);
    return (s == S_IDLE) || (s == S_DONE) || (s == S_ERR);
  endfunction

endpackage

// File: rtl/instr_sequencer_prog_ram.sv
// Program buffer: 2**AW words, one synchronous write port and one
// combinational read port. No reset, the contents survive rst_n.
module prog_ram
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = DATA_W
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  // Write port: store the word on the clock edge.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: combinational, so a word written at the start edge is
  // already visible during the following FETCH cycle.
  always_comb begin
    o_rdata = r_mem[i_raddr];
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: initiator side of the processor run/done
// handshake. Issues buffered words in order until the program length,
// a HALT word, a done timeout or an abort ends the run.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned       AW          = 4,
  parameter logic [DATA_W-1:0] HALT_WORD   = DEF_HALT_WORD,
  parameter int unsigned       TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_we,
  input  logic [AW-1:0]     load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [AW:0]       prog_len,
  input  logic              start,
  input  logic              abort,
  input  logic              done_in,
  output logic [DATA_W-1:0] din_out,
  output logic              run_out,
  output logic              busy,
  output logic              finished,
  output logic              timeout_err,
  output logic [AW-1:0]     pc,
  output logic [15:0]       instr_count
);

  logic [2:0]        r_state;
  logic [AW-1:0]     r_pc;
  logic [AW:0]       r_len;
  logic [31:0]       r_wdog;
  logic [15:0]       r_count;
  logic [DATA_W-1:0] r_din;
  logic              r_run;
  logic              r_finished;
  logic              r_terr;

  logic [2:0]        w_state_nxt;
  logic [DATA_W-1:0] w_rd;
  logic              w_busy;
  logic              w_we;
  logic              w_go;
  logic              w_go_empty;
  logic              w_halt;
  logic              w_done_hit;
  logic              w_last;
  logic              w_expire;
  logic              w_to_done;

  prog_ram #(
    .AW (AW),
    .DW (DATA_W)
  ) u_prog_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_raddr (r_pc),
    .o_rdata (w_rd)
  );

  // Decode the events that steer the FSM this cycle.
  always_comb begin
    w_busy     = state_is_busy(r_state);
    w_we       = load_we && !w_busy;
    w_go       = state_is_quiet(r_state) && start;
    w_go_empty = w_go && (prog_len == '0);
    w_halt     = (r_state == S_FETCH) && (w_rd == HALT_WORD);
    w_done_hit = (r_state == S_WAIT) && done_in;
    w_last     = (({1'b0, r_pc}) + (AW+1)'(1)) == r_len;
    // done_in in the expiry cycle wins: the instruction completes instead.
    w_expire   = (r_state == S_WAIT) && !done_in && (TIMEOUT_CYC != 0) &&
                 (r_wdog == (TIMEOUT_CYC - 32'd1));
    w_to_done  = w_go_empty || w_halt || (w_done_hit && w_last);
  end

  // Next-state selection; abort is applied with priority in the register.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (w_go) begin
          w_state_nxt = w_go_empty ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        w_state_nxt = w_halt ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_done_hit) begin
          w_state_nxt = w_last ? S_DONE : S_FETCH;
        end else if (w_expire) begin
          w_state_nxt = S_ERR;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (abort) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Program counter, captured length and completed-instruction counter.
  // On the final done, pc stays on the last word rather than stepping past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= '0;
      r_len   <= '0;
      r_count <= '0;
    end else if (!abort) begin
      if (w_go) begin
        r_pc    <= '0;
        r_len   <= prog_len;
        r_count <= '0;
      end else if (w_done_hit) begin
        if (r_count != '1) begin
          r_count <= r_count + 16'd1;
        end
        if (!w_last) begin
          r_pc <= r_pc + AW'(1);
        end
      end
    end
  end

  // Instruction word and run pulse toward the processor. The pulse is
  // registered out of ISSUE so it is high for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_din <= '0;
      r_run <= 1'b0;
    end else if (abort) begin
      r_run <= 1'b0;
    end else begin
      r_run <= (r_state == S_ISSUE);
      if ((r_state == S_FETCH) && !w_halt) begin
        r_din <= w_rd;
      end
    end
  end

  // Done watchdog: cleared on issue, counts every WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wdog <= '0;
    end else if ((r_state == S_WAIT) && (TIMEOUT_CYC != 0)) begin
      r_wdog <= r_wdog + 32'd1;
    end
  end

  // Completion and sticky timeout flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_finished <= 1'b0;
      r_terr     <= 1'b0;
    end else if (abort) begin
      r_finished <= 1'b0;
      r_terr     <= 1'b0;
    end else begin
      if (w_to_done) begin
        r_finished <= 1'b1;
      end else if (w_go) begin
        r_finished <= 1'b0;
      end
      if (w_expire) begin
        r_terr <= 1'b1;
      end else if (w_go) begin
        r_terr <= 1'b0;
      end
    end
  end

  // Output mapping.
  always_comb begin
    din_out     = r_din;
    run_out     = r_run;
    busy        = w_busy;
    finished    = r_finished;
    timeout_err = r_terr;
    pc          = r_pc;
    instr_count = r_count;
  end

endmodule
